// File: rtl/uart_pkg.sv
// Shared UART receive types and 8N1 frame constants.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_front_if.sv
// Read-side bus of the UART receive front end.
interface uart_front_if #(
    parameter int ADDR_W = 10
);

    logic              rd_en;
    logic              clr_err;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              ferr;

    modport master (
        output rd_en, clr_err,
        input  rd_data, rd_valid, count, overflow, ferr
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, rd_valid, count, overflow, ferr
    );

endinterface

// File: rtl/uart_rx.sv
// Serial deserializer: rxd synchronizer plus 8N1 receive FSM.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       push_o,
    output logic       ferr_o
);

    localparam int FULL = 2 * CLK_PER_HALF_BIT;
    localparam int CW   = $clog2(FULL + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(FULL - 1);

    logic            sync1_q, sync2_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shr_q, shr_d;
    logic            push_q, push_d;
    logic            ferr_q, ferr_d;
    logic            brk_q, brk_d;
    logic            rx;

    assign rx = sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shr_q   <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shr_q   <= shr_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shr_d   = shr_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = brk_q;
        unique case (state_q)
            IDLE: begin
                if (!rx) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    shr_d = {rx, shr_q[DATA_BITS-1:1]};
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 3'(DATA_BITS - 1))
                        state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // After a bad stop bit, park here until the line idles high
                if (brk_q) begin
                    if (rx == STOP_LVL) begin
                        brk_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx == STOP_LVL) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d = 1'b1;
                        brk_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_o = shr_q;
    assign push_o = push_q;
    assign ferr_o = ferr_q;

endmodule

// File: rtl/uart_front.sv
// UART receive front end: deserializer feeding a show-ahead byte FIFO.
module uart_front
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int ADDR_W           = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rxd,
    uart_front_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        rx_byte;
    logic              rx_push;
    logic              rx_ferr;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              ferr_q, ferr_d;
    logic              do_pop, do_push, full, nonempty;

    uart_rx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rxd_i  (rxd),
        .byte_o (rx_byte),
        .push_o (rx_push),
        .ferr_o (rx_ferr)
    );

    assign nonempty = (count_q != '0);
    assign full     = (count_q == FULL_CNT);
    assign do_pop   = bus.rd_en && nonempty;
    // A pop in the same cycle frees the slot for a push into a full FIFO
    assign do_push  = rx_push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d  = ovf_q;
        ferr_d = ferr_q;
        if (bus.clr_err) begin
            ovf_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (rx_push && !do_push)
            ovf_d = 1'b1;
        if (rx_ferr)
            ferr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= rx_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.rd_valid = nonempty;
    assign bus.rd_data  = nonempty ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.ferr     = ferr_q;

endmodule

// File: tb/tb_uart_front.sv
// Scoreboard bench: full-rate DUT for timing/errors, small fast DUT for FIFO limits.
module tb_uart_front;

    localparam int HA = 434;
    localparam int HB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rxd_a, rxd_b;

    uart_front_if #(.ADDR_W(10)) bus_a ();
    uart_front_if #(.ADDR_W(2))  bus_b ();

    uart_front dut_a (
        .clk (clk),
        .rst (rst_a),
        .rxd (rxd_a),
        .bus (bus_a)
    );

    uart_front #(
        .CLK_PER_HALF_BIT(HB),
        .ADDR_W(2)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .rxd (rxd_b),
        .bus (bus_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_v = -1;
    int t0 = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always @(posedge clk) cyc++;

    always @(negedge clk)
        if (bus_a.rd_valid && first_v < 0)
            first_v = cyc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT performs is checked against the scoreboard
    always @(negedge clk) begin
        if (bus_a.rd_en && bus_a.rd_valid) begin
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_a: got %02h want nothing", bus_a.rd_data);
            end else begin
                chk("pop_a", {24'h0, bus_a.rd_data}, {24'h0, q_a.pop_front()});
            end
        end
        if (bus_b.rd_en && bus_b.rd_valid) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_b: got %02h want nothing", bus_b.rd_data);
            end else begin
                chk("pop_b", {24'h0, bus_b.rd_data}, {24'h0, q_b.pop_front()});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else     rxd_a = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic stop);
        int bt;
        bt = sel ? 2 * HB : 2 * HA;
        @(negedge clk);
        t0 = cyc;
        drive(sel, 1'b0);
        cycles(bt);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            cycles(bt);
        end
        drive(sel, stop);
        cycles(bt);
        drive(sel, 1'b1);
        cycles(bt);
    endtask

    function automatic logic vld(input bit sel);
        return sel ? bus_b.rd_valid : bus_a.rd_valid;
    endfunction

    task automatic pulse_rd(input bit sel);
        @(posedge clk);
        #1;
        if (sel) bus_b.rd_en = 1'b1;
        else     bus_a.rd_en = 1'b1;
        @(posedge clk);
        #1;
        if (sel) bus_b.rd_en = 1'b0;
        else     bus_a.rd_en = 1'b0;
    endtask

    task automatic read_one(input bit sel);
        int n;
        n = 0;
        while (!vld(sel) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!vld(sel)) begin
            total++;
            bad++;
            $display("FAIL read_timeout: got rd_valid=0 want 1 (dut %0d)", sel);
        end else begin
            pulse_rd(sel);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        bus_a.rd_en = 1'b0;
        bus_a.clr_err = 1'b0;
        bus_b.rd_en = 1'b0;
        bus_b.clr_err = 1'b0;
        cycles(3);
        chk("rst_count", 32'(bus_a.count), 0);
        chk("rst_valid", 32'(bus_a.rd_valid), 0);
        chk("rst_data", 32'(bus_a.rd_data), 0);
        chk("rst_ovf", 32'(bus_b.overflow), 0);
        chk("rst_ferr", 32'(bus_a.ferr), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        cycles(5);

        // 0x55 at full rate, with start-edge-to-valid latency
        q_a.push_back(8'h55);
        send(1'b0, 8'h55, 1'b1);
        chk("lat_55", 32'(first_v >= 0 && (first_v - t0) <= 20 * HA + 4), 1);
        chk("cnt_55", 32'(bus_a.count), 1);
        read_one(1'b0);
        cycles(2);
        chk("cnt_55_rd", 32'(bus_a.count), 0);

        // short low glitch is a false start
        @(negedge clk);
        rxd_a = 1'b0;
        cycles(300);
        rxd_a = 1'b1;
        cycles(2000);
        chk("glitch_cnt", 32'(bus_a.count), 0);
        chk("glitch_ferr", 32'(bus_a.ferr), 0);

        // bad stop bit, then a good frame
        send(1'b0, 8'hA3, 1'b0);
        chk("ferr_set", 32'(bus_a.ferr), 1);
        chk("ferr_cnt", 32'(bus_a.count), 0);
        q_a.push_back(8'h3C);
        send(1'b0, 8'h3C, 1'b1);
        chk("cnt_3c", 32'(bus_a.count), 1);
        chk("data_3c", 32'(bus_a.rd_data), 32'h3C);
        chk("ferr_sticky", 32'(bus_a.ferr), 1);

        // reset in the middle of data bit 4
        @(negedge clk);
        rxd_a = 1'b0;
        cycles(2 * HA);
        for (int i = 0; i < 4; i++) begin
            rxd_a = i[0];
            cycles(2 * HA);
        end
        rxd_a = 1'b1;
        cycles(HA);
        rst_a = 1'b1;
        #1;
        chk("mrst_cnt", 32'(bus_a.count), 0);
        chk("mrst_valid", 32'(bus_a.rd_valid), 0);
        chk("mrst_data", 32'(bus_a.rd_data), 0);
        chk("mrst_ferr", 32'(bus_a.ferr), 0);
        q_a.delete();
        cycles(5);
        rst_a = 1'b0;
        cycles(4 * HA);
        chk("mrst_idle", 32'(bus_a.count), 0);
        q_a.push_back(8'hF0);
        send(1'b0, 8'hF0, 1'b1);
        chk("cnt_f0", 32'(bus_a.count), 1);
        read_one(1'b0);

        // overflow on the 4-entry FIFO
        for (int v = 1; v <= 5; v++) begin
            if (v <= 4) q_b.push_back(8'(v));
            send(1'b1, 8'(v), 1'b1);
        end
        chk("ovf_cnt", 32'(bus_b.count), 4);
        chk("ovf_set", 32'(bus_b.overflow), 1);
        for (int i = 0; i < 4; i++) read_one(1'b1);
        cycles(2);
        chk("ovf_drain", 32'(bus_b.count), 0);
        chk("ovf_sticky", 32'(bus_b.overflow), 1);
        pulse_rd(1'b1);
        chk("empty_rd", 32'(bus_b.count), 0);
        @(posedge clk);
        #1;
        bus_b.clr_err = 1'b1;
        @(posedge clk);
        #1;
        bus_b.clr_err = 1'b0;
        chk("clr_ovf", 32'(bus_b.overflow), 0);

        // full FIFO: pop in the very cycle the fifth byte is pushed
        for (int v = 1; v <= 4; v++) begin
            q_b.push_back(8'(v));
            send(1'b1, 8'(v), 1'b1);
        end
        q_b.push_back(8'h05);
        fork
            send(1'b1, 8'h05, 1'b1);
            begin
                int n;
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!dut_b.u_rx.push_o && n < 400);
                if (!dut_b.u_rx.push_o) begin
                    total++;
                    bad++;
                    $display("FAIL push_timeout: got no push want one");
                end else begin
                    bus_b.rd_en = 1'b1;
                    @(posedge clk);
                    #1;
                    bus_b.rd_en = 1'b0;
                end
            end
        join
        chk("full_rw_cnt", 32'(bus_b.count), 4);
        chk("full_rw_ovf", 32'(bus_b.overflow), 0);
        for (int i = 0; i < 4; i++) read_one(1'b1);
        cycles(2);
        chk("full_rw_drain", 32'(bus_b.count), 0);
        chk("sb_empty", 32'(q_a.size() + q_b.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_front.md
UART_FRONT -- requirements
Module: uart_front

Interface
REQ-001 The block SHALL have parameter CLK_PER_HALF_BIT, default 434, meaning clk cycles per half UART bit period.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning the FIFO holds 2**ADDR_W bytes.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-005 The block SHALL have port rxd, input, 1, the serial line (8N1, LSB first, idle high), asynchronous to clk.
REQ-006 The block SHALL have port rd_en, input, 1, which pops the head byte when rd_valid=1.
REQ-007 The block SHALL have port rd_data, output, 8, the FIFO head byte (show-ahead).
REQ-008 The block SHALL have port rd_valid, output, 1, which is high when the FIFO is non-empty.
REQ-009 The block SHALL have port count, output, ADDR_W+1, the number of bytes currently stored.
REQ-010 The block SHALL have port overflow, output, 1, sticky: a received byte was dropped because the FIFO was full.
REQ-011 The block SHALL have port ferr, output, 1, sticky: a frame had stop bit = 0.
REQ-012 The block SHALL have port clr_err, input, 1, which clears overflow and ferr.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer, with both flops resetting to 1; all sampling uses the synchronized value.
REQ-014 The receiver FSM SHALL have states IDLE, START, DATA and STOP, plus a bit-period counter and a 3-bit bit index.
REQ-015 In IDLE, synchronized rxd=0 SHALL move the FSM to START and clear the counter.
REQ-016 In START, after CLK_PER_HALF_BIT cycles, the FSM SHALL sample rxd: 0 moves to DATA; 1 is a false start and returns to IDLE with nothing stored.
REQ-017 In DATA, the FSM SHALL sample one bit every 2*CLK_PER_HALF_BIT cycles into bit index 0..7 (LSB first), then move to STOP.
REQ-018 In STOP, after 2*CLK_PER_HALF_BIT cycles, the FSM SHALL sample rxd: 1 issues a one-cycle push strobe of the assembled byte and returns to IDLE.
REQ-019 In STOP, a sampled 0 SHALL set ferr, discard the byte, and hold the FSM until rxd=1 before returning to IDLE.
REQ-020 A push strobe at cycle N SHALL be visible as rd_valid=1 and rd_data=byte at cycle N+1, and count SHALL update at N+1.
REQ-021 A push while count=2**ADDR_W and rd_en=0 SHALL drop the byte, set overflow, and leave the FIFO contents and count unchanged.
REQ-022 A push while full with rd_en=1 in the same cycle SHALL perform both the pop and the push, leaving count unchanged.
REQ-023 A simultaneous push and pop while non-empty SHALL leave count unchanged; the head SHALL advance and the new byte SHALL be appended.
REQ-024 rd_en while empty SHALL be ignored, with no pointer or count change.
REQ-025 Read and write pointers SHALL be ADDR_W bits and wrap modulo 2**ADDR_W; count SHALL never exceed 2**ADDR_W.
REQ-026 clr_err SHALL clear overflow and ferr on the next cycle; a simultaneous set event SHALL win over clr_err.
REQ-027 rd_data SHALL be don't-care while rd_valid=0.

Reset
REQ-028 rst SHALL asynchronously force: FSM to IDLE, counters and bit index to 0, pointers to 0, count=0, rd_valid=0, overflow=0, ferr=0, rd_data=0, synchronizer flops to 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL begin only on a new falling edge.
REQ-030 FIFO memory contents SHALL NOT be reset.

Structure
REQ-031 The rx FSM state enum and the UART frame constants (data bits = 8, stop level = 1) SHALL reside in the shared uart_pkg package.
REQ-032 The serial deserializer (synchronizer plus FSM, producing byte and push strobe) SHALL be a sub-module named uart_rx; the FIFO and flags SHALL live in uart_front.

Verification
REQ-033 Send 0x55 at CLK_PER_HALF_BIT=434 -> rd_valid=1 and rd_data=0x55 within 20*434+4 cycles of the start edge; count=1.
REQ-034 Drive a 300-cycle low glitch on idle rxd -> no push, count=0, ferr=0.
REQ-035 Send 0xA3 with stop bit held low for one bit, then release -> ferr=1, count=0; a following 0x3C is received correctly.
REQ-036 With ADDR_W=2, send 0x01..0x05 without reading -> count=4, overflow=1, and reads return 0x01, 0x02, 0x03, 0x04.
REQ-037 With ADDR_W=2 full, pulse rd_en in the push cycle of 0x05 -> count stays 4, overflow=0, and reads return 0x02, 0x03, 0x04, 0x05.
REQ-038 Assert rst during DATA bit 4 of a frame -> all outputs reach their reset values immediately; the next full frame 0xF0 is received correctly.
